// File: rtl/console_probe_if.sv
// Probe bundle between the multicart top level and console_probe.
// Holds the PPU sense inputs, reprobe request and verdict outputs.
interface console_probe_if;
    logic       ppu_rd_in;
    logic       ppu_a13_in;
    logic       ppu_not_a13_in;
    logic       reprobe;
    logic       hold_low;
    logic       init_done;
    logic       result_valid;
    logic [1:0] console_type;
    logic       new_famiclone;
    logic [3:0] mismatch_count;

    modport master (
        output ppu_rd_in, ppu_a13_in, ppu_not_a13_in, reprobe,
        input  hold_low, init_done, result_valid,
        input  console_type, new_famiclone, mismatch_count
    );

    modport slave (
        input  ppu_rd_in, ppu_a13_in, ppu_not_a13_in, reprobe,
        output hold_low, init_done, result_valid,
        output console_type, new_famiclone, mismatch_count
    );
endinterface

// File: rtl/console_probe.sv
// Power-on console detector: classic console vs new famiclone via /A13 probing.
// Optional probe timeout enabled by defining CONSOLE_PROBE_TIMEOUT_EN.
module console_probe #(
    parameter int INIT_CYCLES  = 15,
    parameter int PROBE_READS  = 3,
    parameter int MISMATCH_MIN = 1
`ifdef CONSOLE_PROBE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input logic              m2,
    input logic              reset,
    console_probe_if.slave   p
);
    typedef enum logic [1:0] {
        S_INIT,
        S_PROBE,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] init_cnt_q;
    logic [3:0] lo_left_q, hi_left_q, mis_q;
    logic [3:0] lo_left_d, hi_left_d, mis_d;
    logic [1:0] type_q;
    logic       hold_low_q, init_done_q, valid_q, newfc_q;
    logic       ppu_rd_q;
    logic       rd_event, mis_hit, all_done, timed_out;

    assign rd_event = ppu_rd_q & ~p.ppu_rd_in;

    always_comb begin
        mis_d     = mis_q;
        lo_left_d = lo_left_q;
        hi_left_d = hi_left_q;
        if (rd_event) begin
            // Mismatches only count while both polarities still need samples
            if (lo_left_q != 4'd0 && hi_left_q != 4'd0 &&
                p.ppu_a13_in == p.ppu_not_a13_in && mis_q != 4'hf)
                mis_d = mis_q + 4'd1;
            if (!p.ppu_a13_in && lo_left_q != 4'd0)
                lo_left_d = lo_left_q - 4'd1;
            if (p.ppu_a13_in && hi_left_q != 4'd0)
                hi_left_d = hi_left_q - 4'd1;
        end
    end

    assign mis_hit  = (32'(mis_d) >= 32'(MISMATCH_MIN));
    assign all_done = (lo_left_d == 4'd0) && (hi_left_d == 4'd0);

`ifdef CONSOLE_PROBE_TIMEOUT_EN
    logic [15:0] to_q, to_d;
    assign to_d      = to_q + 16'd1;
    assign timed_out = (to_d == 16'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge m2) begin
        ppu_rd_q <= p.ppu_rd_in;
        if (reset) begin
            state_q     <= S_INIT;
            init_cnt_q  <= 8'(INIT_CYCLES);
            lo_left_q   <= 4'(PROBE_READS);
            hi_left_q   <= 4'(PROBE_READS);
            mis_q       <= 4'd0;
            type_q      <= 2'b00;
            hold_low_q  <= 1'b1;
            init_done_q <= 1'b0;
            valid_q     <= 1'b0;
            newfc_q     <= 1'b0;
            ppu_rd_q    <= 1'b1;
`ifdef CONSOLE_PROBE_TIMEOUT_EN
            to_q        <= 16'd0;
`endif
        end else begin
            unique case (state_q)
                S_INIT: begin
                    if (init_cnt_q == 8'd0) begin
                        state_q     <= S_PROBE;
                        hold_low_q  <= 1'b0;
                        init_done_q <= 1'b1;
                        lo_left_q   <= 4'(PROBE_READS);
                        hi_left_q   <= 4'(PROBE_READS);
                        mis_q       <= 4'd0;
`ifdef CONSOLE_PROBE_TIMEOUT_EN
                        to_q        <= 16'd0;
`endif
                    end else begin
                        init_cnt_q <= init_cnt_q - 8'd1;
                    end
                end
                S_PROBE: begin
                    mis_q     <= mis_d;
                    lo_left_q <= lo_left_d;
                    hi_left_q <= hi_left_d;
`ifdef CONSOLE_PROBE_TIMEOUT_EN
                    to_q      <= to_d;
`endif
                    if (mis_hit) begin
                        state_q <= S_DONE;
                        type_q  <= 2'b10;
                        newfc_q <= 1'b1;
                        valid_q <= 1'b1;
                    end else if (all_done) begin
                        state_q <= S_DONE;
                        type_q  <= 2'b01;
                        valid_q <= 1'b1;
                    end else if (timed_out) begin
                        state_q <= S_DONE;
                        type_q  <= 2'b11;
                        valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (p.reprobe) begin
                        state_q   <= S_PROBE;
                        mis_q     <= 4'd0;
                        lo_left_q <= 4'(PROBE_READS);
                        hi_left_q <= 4'(PROBE_READS);
                        type_q    <= 2'b00;
                        newfc_q   <= 1'b0;
                        valid_q   <= 1'b0;
`ifdef CONSOLE_PROBE_TIMEOUT_EN
                        to_q      <= 16'd0;
`endif
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign p.hold_low       = hold_low_q;
    assign p.init_done      = init_done_q;
    assign p.result_valid   = valid_q;
    assign p.console_type   = type_q;
    assign p.new_famiclone  = newfc_q;
    assign p.mismatch_count = mis_q;
endmodule

// File: tb/tb_console_probe.sv
// Scoreboard bench for console_probe: two instances (default and MISMATCH_MIN=2).
// Verdicts are queued as expected records and checked by a monitor on result_valid rise.
module tb_console_probe;
    typedef struct {
        int         dut;
        logic [1:0] ty;
        logic [3:0] mc;
        int         edge_n;
    } exp_t;

    logic       m2 = 1'b0;
    logic [1:0] rst, rd, a13, na13, rp;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_tot = 0;
    logic       pv0 = 1'b0;
    logic       pv1 = 1'b0;
    exp_t       sb[$];

    console_probe_if if0 ();
    console_probe_if if1 ();

    assign if0.ppu_rd_in      = rd[0];
    assign if0.ppu_a13_in     = a13[0];
    assign if0.ppu_not_a13_in = na13[0];
    assign if0.reprobe        = rp[0];
    assign if1.ppu_rd_in      = rd[1];
    assign if1.ppu_a13_in     = a13[1];
    assign if1.ppu_not_a13_in = na13[1];
    assign if1.reprobe        = rp[1];

`ifdef CONSOLE_PROBE_TIMEOUT_EN
    console_probe #(.TIMEOUT_CYCLES(100)) u0 (
        .m2(m2), .reset(rst[0]), .p(if0)
    );
`else
    console_probe u0 (
        .m2(m2), .reset(rst[0]), .p(if0)
    );
`endif

    console_probe #(.MISMATCH_MIN(2)) u1 (
        .m2(m2), .reset(rst[1]), .p(if1)
    );

    initial forever #5 m2 = ~m2;

    always @(posedge m2) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)",
                      nm, act, exp, cyc);
    endtask

    task automatic mon(input int d, input logic [1:0] ty,
                       input logic [3:0] mc, input logic nf);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_verdict", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("sb_dut", d, e.dut);
            chk("sb_type", int'(ty), int'(e.ty));
            chk("sb_mcount", int'(mc), int'(e.mc));
            chk("sb_newfc", int'(nf), int'(e.ty == 2'b10));
            chk("sb_edge", cyc, e.edge_n);
        end
    endtask

    always @(negedge m2) begin
        if (if0.result_valid && !pv0)
            mon(0, if0.console_type, if0.mismatch_count, if0.new_famiclone);
        if (if1.result_valid && !pv1)
            mon(1, if1.console_type, if1.mismatch_count, if1.new_famiclone);
        pv0 <= if0.result_valid;
        pv1 <= if1.result_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge m2);
        #1;
    endtask

    task automatic rdev(input int d, input logic a, input logic n);
        rd[d]   = 1'b0;
        a13[d]  = a;
        na13[d] = n;
        tick(1);
        rd[d] = 1'b1;
        tick(1);
    endtask

    task automatic expect_v(input int d, input logic [1:0] ty,
                            input logic [3:0] mc, input int dly);
        sb.push_back('{d, ty, mc, cyc + dly});
    endtask

    task automatic good_reads(input int d);
        rdev(d, 1'b0, 1'b1);
        rdev(d, 1'b0, 1'b1);
        rdev(d, 1'b0, 1'b1);
        rdev(d, 1'b1, 1'b0);
        rdev(d, 1'b1, 1'b0);
        expect_v(d, 2'b01, 4'd0, 1);
        rdev(d, 1'b1, 1'b0);
    endtask

    task automatic pulse_rp(input int d);
        rp[d] = 1'b1;
        tick(1);
        rp[d] = 1'b0;
    endtask

    initial begin
        rst  = 2'b11;
        rd   = 2'b11;
        a13  = 2'b00;
        na13 = 2'b11;
        rp   = 2'b00;
        tick(3);
        chk("rst_hold", int'(if0.hold_low), 1);
        chk("rst_init_done", int'(if0.init_done), 0);
        chk("rst_valid", int'(if0.result_valid), 0);
        chk("rst_type", int'(if0.console_type), 0);
        chk("rst_newfc", int'(if0.new_famiclone), 0);
        chk("rst_mcount", int'(if0.mismatch_count), 0);

        rst[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("init_hold", int'(if0.hold_low), int'(k < 16));
            chk("init_done", int'(if0.init_done), int'(k >= 16));
        end

        good_reads(0);
        tick(1);

        pulse_rp(0);
        chk("rp_type", int'(if0.console_type), 0);
        chk("rp_valid", int'(if0.result_valid), 0);
        chk("rp_hold", int'(if0.hold_low), 0);
        chk("rp_mcount", int'(if0.mismatch_count), 0);

        expect_v(0, 2'b10, 4'd1, 1);
        rdev(0, 1'b0, 1'b0);
        chk("fc_newfc", int'(if0.new_famiclone), 1);

        rp[0]   = 1'b1;
        rd[0]   = 1'b0;
        a13[0]  = 1'b0;
        na13[0] = 1'b0;
        tick(1);
        rp[0] = 1'b0;
        rd[0] = 1'b1;
        chk("rp_rd_mcount", int'(if0.mismatch_count), 0);
        chk("rp_rd_type", int'(if0.console_type), 0);
        tick(1);
        good_reads(0);
        tick(1);

`ifdef CONSOLE_PROBE_TIMEOUT_EN
        pulse_rp(0);
        expect_v(0, 2'b11, 4'd0, 100);
        tick(99);
        chk("to_pre", int'(if0.console_type), 0);
        tick(3);
        chk("to_type", int'(if0.console_type), 3);
        pulse_rp(0);
        chk("to_rp_type", int'(if0.console_type), 0);
        chk("to_rp_valid", int'(if0.result_valid), 0);
        good_reads(0);
        tick(1);
`endif

        rst[1] = 1'b0;
        tick(17);
        chk("u1_init_done", int'(if1.init_done), 1);
        rdev(1, 1'b0, 1'b0);
        chk("u1_mcount", int'(if1.mismatch_count), 1);
        chk("u1_no_early", int'(if1.result_valid), 0);
        rdev(1, 1'b0, 1'b1);
        rdev(1, 1'b0, 1'b1);
        rdev(1, 1'b1, 1'b0);
        rdev(1, 1'b1, 1'b0);
        expect_v(1, 2'b01, 4'd1, 1);
        rdev(1, 1'b1, 1'b0);
        tick(1);

        pulse_rp(1);
        rdev(1, 1'b0, 1'b0);
        rdev(1, 1'b1, 1'b0);
        chk("mid_mcount", int'(if1.mismatch_count), 1);
        rst[1] = 1'b1;
        tick(1);
        chk("mid_hold", int'(if1.hold_low), 1);
        chk("mid_init_done", int'(if1.init_done), 0);
        chk("mid_valid", int'(if1.result_valid), 0);
        chk("mid_type", int'(if1.console_type), 0);
        chk("mid_newfc", int'(if1.new_famiclone), 0);
        chk("mid_mcount_rst", int'(if1.mismatch_count), 0);
        rst[1] = 1'b0;
        tick(15);
        chk("mid_rehold", int'(if1.hold_low), 1);
        tick(1);
        chk("mid_release", int'(if1.hold_low), 0);

        tick(3);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
